io_port_hub: RTL and testbench

- Parametrised I/O port decoder between the processor's IO strobe bus and NUM_CH byte-stream UART channels, plus one GPIO output register and one synchronised GPIO input.
- Successor to the fixed single-UART decode in the top level.
- Adds per-channel status, sticky error flags, a control port, a scratch register and a registered read path with fixed latency.
- Sits in top, between processor_top and the rs232_uart instances.

---
 rtl/io_port_hub_if.sv | 19 +
 rtl/io_port_hub.sv | 151 +++++++++++++++
 tb/tb_io_port_hub.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_hub_if.sv
// Processor IO strobe bus: port address, write data/strobe, read strobe and
// the registered read data returned by the port decoder.
interface io_port_hub_if;
  logic [7:0] IO_port_ID;
  logic [7:0] IO_write_data;
  logic       IO_write_strobe;
  logic       IO_read_strobe;
  logic [7:0] IO_read_data;

  modport master (
    output IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe,
    input  IO_read_data
  );

  modport slave (
    input  IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe,
    output IO_read_data
  );
endinterface

// File: rtl/io_port_hub.sv
// IO port decoder: NUM_CH UART channels (DATA/STATUS/CONTROL/SCRATCH each),
// a GPIO output register and a synchronised GPIO input, with one-cycle read latency.
module io_port_hub #(
  parameter int         NUM_CH        = 2,
  parameter logic [7:0] BASE_PORT     = 8'h10,
  parameter logic [7:0] GPIO_OUT_PORT = 8'h01,
  parameter logic [7:0] GPIO_IN_PORT  = 8'h02
) (
  input  logic                  clk,
  input  logic                  reset,
  io_port_hub_if.slave          bus,
  output logic [8*NUM_CH-1:0]   uart_tx_data,
  output logic [NUM_CH-1:0]     uart_write_tx,
  input  logic [NUM_CH-1:0]     uart_tx_full,
  input  logic [8*NUM_CH-1:0]   uart_rx_data,
  input  logic [NUM_CH-1:0]     uart_rx_present,
  output logic [NUM_CH-1:0]     uart_read_ack,
  output logic [7:0]            gpio_out,
  input  logic [7:0]            gpio_in
);

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_SCRATCH = 2'd3
  } reg_e;

  logic [NUM_CH-1:0][7:0] tx_data_q;
  logic [NUM_CH-1:0][7:0] scratch_q;
  logic [NUM_CH-1:0]      write_tx_q;
  logic [NUM_CH-1:0]      read_ack_q;
  logic [NUM_CH-1:0]      rx_underflow_q;
  logic [NUM_CH-1:0]      tx_dropped_q;
  logic [7:0]             read_data_q;
  logic [7:0]             gpio_out_q;
  logic [7:0]             gpio_sync1_q;
  logic [7:0]             gpio_sync2_q;

  logic [8:0]        diff;
  logic [5:0]        ch_word;
  logic              ch_hit;
  reg_e              reg_off;
  logic [NUM_CH-1:0] ch_sel;
  logic              rd_en;
  logic              wr_en;
  logic [7:0]        rd_mux;

  // A borrow in diff[8] means the port lies below the channel window.
  assign diff    = {1'b0, bus.IO_port_ID} - {1'b0, BASE_PORT};
  assign ch_word = diff[7:2];
  assign ch_hit  = !diff[8] && (ch_word < 6'(NUM_CH));
  assign reg_off = reg_e'(diff[1:0]);

  // A read strobe wins; a simultaneous write is dropped with no side effects.
  assign rd_en = bus.IO_read_strobe;
  assign wr_en = bus.IO_write_strobe && !bus.IO_read_strobe;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    ch_sel = '0;
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_sel[c] = ch_hit && (ch_word == 6'(c));
    end
    if (ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel[c]) begin
          case (reg_off)
            REG_DATA:    rd_mux = uart_rx_present[c] ? uart_rx_data[8*c +: 8] : 8'h00;
            REG_STATUS:  rd_mux = {4'b0000, tx_dropped_q[c], rx_underflow_q[c],
                                   uart_tx_full[c], uart_rx_present[c]};
            REG_CONTROL: rd_mux = 8'h00;
            REG_SCRATCH: rd_mux = scratch_q[c];
            default:     rd_mux = 8'h00;
          endcase
        end
      end
    end else if (bus.IO_port_ID == GPIO_OUT_PORT) begin
      rd_mux = gpio_out_q;
    end else if (bus.IO_port_ID == GPIO_IN_PORT) begin
      rd_mux = gpio_sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      // NOTE: the small per-channel arrays are ordinary flops, so resetting them is cheap and required.
      tx_data_q      <= '0;
      scratch_q      <= '0;
      write_tx_q     <= '0;
      read_ack_q     <= '0;
      rx_underflow_q <= '0;
      tx_dropped_q   <= '0;
      read_data_q    <= '0;
      gpio_out_q     <= '0;
      gpio_sync1_q   <= '0;
      gpio_sync2_q   <= '0;
    end else begin
      gpio_sync1_q <= gpio_in;
      gpio_sync2_q <= gpio_sync1_q;
      write_tx_q   <= '0;
      read_ack_q   <= '0;

      if (rd_en) begin
        read_data_q <= rd_mux;
      end

      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel[c]) begin
          if (rd_en && reg_off == REG_DATA) begin
            if (uart_rx_present[c]) read_ack_q[c]     <= 1'b1;
            else                    rx_underflow_q[c] <= 1'b1;
          end
          if (wr_en) begin
            case (reg_off)
              REG_DATA: begin
                if (!uart_tx_full[c]) begin
                  tx_data_q[c]  <= bus.IO_write_data;
                  write_tx_q[c] <= 1'b1;
                end else begin
                  tx_dropped_q[c] <= 1'b1;
                end
              end
              REG_CONTROL: begin
                if (bus.IO_write_data[0]) begin
                  rx_underflow_q[c] <= 1'b0;
                  tx_dropped_q[c]   <= 1'b0;
                end
              end
              REG_SCRATCH: scratch_q[c] <= bus.IO_write_data;
              default: ;
            endcase
          end
        end
      end

      if (wr_en && !ch_hit && bus.IO_port_ID == GPIO_OUT_PORT) begin
        gpio_out_q <= bus.IO_write_data;
      end
    end
  end

  assign bus.IO_read_data = read_data_q;
  assign uart_tx_data     = tx_data_q;
  assign uart_write_tx    = write_tx_q;
  assign uart_read_ack    = read_ack_q;
  assign gpio_out         = gpio_out_q;

endmodule

// File: tb/tb_io_port_hub.sv
// Self-checking bench for io_port_hub: directed port-map scenarios followed by
// randomized traffic, all checked against a port-map level reference model.
module tb_io_port_hub;

  localparam int         NUM_CH        = 2;
  localparam logic [7:0] BASE_PORT     = 8'h10;
  localparam logic [7:0] GPIO_OUT_PORT = 8'h01;
  localparam logic [7:0] GPIO_IN_PORT  = 8'h02;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [8*NUM_CH-1:0] uart_tx_data;
  logic [NUM_CH-1:0]   uart_write_tx;
  logic [NUM_CH-1:0]   uart_tx_full = '0;
  logic [8*NUM_CH-1:0] uart_rx_data = '0;
  logic [NUM_CH-1:0]   uart_rx_present = '0;
  logic [NUM_CH-1:0]   uart_read_ack;
  logic [7:0]          gpio_out;
  logic [7:0]          gpio_in = '0;

  io_port_hub_if bus();

  io_port_hub #(
    .NUM_CH(NUM_CH), .BASE_PORT(BASE_PORT),
    .GPIO_OUT_PORT(GPIO_OUT_PORT), .GPIO_IN_PORT(GPIO_IN_PORT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .uart_tx_data(uart_tx_data), .uart_write_tx(uart_write_tx),
    .uart_tx_full(uart_tx_full), .uart_rx_data(uart_rx_data),
    .uart_rx_present(uart_rx_present), .uart_read_ack(uart_read_ack),
    .gpio_out(gpio_out), .gpio_in(gpio_in)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_rdata;
  logic [7:0] m_gpio;
  logic [7:0] m_tx   [NUM_CH];
  logic [7:0] m_scr  [NUM_CH];
  bit         m_under[NUM_CH];
  bit         m_drop [NUM_CH];
  logic [7:0] gin_p1;   // gpio_in one cycle ago
  logic [7:0] gin_p2;   // gpio_in two cycles ago

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ch_of(input logic [7:0] p);
    int d;
    d = int'(p) - int'(BASE_PORT);
    if (d >= 0 && d < 4 * NUM_CH) return d / 4;
    return -1;
  endfunction

  function automatic int off_of(input logic [7:0] p);
    return (int'(p) - int'(BASE_PORT)) % 4;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] p);
    int c;
    c = ch_of(p);
    if (c >= 0) begin
      case (off_of(p))
        0: return uart_rx_present[c] ? uart_rx_data[8*c +: 8] : 8'h00;
        1: return {4'b0000, m_drop[c], m_under[c], uart_tx_full[c], uart_rx_present[c]};
        2: return 8'h00;
        default: return m_scr[c];
      endcase
    end
    if (p == GPIO_OUT_PORT) return m_gpio;
    if (p == GPIO_IN_PORT)  return gin_p2;
    return 8'h00;
  endfunction

  // One bus cycle: drive at negedge, update model, check just after the edge.
  task automatic do_op(input bit rst, input bit rd, input bit wr,
                       input logic [7:0] port, input logic [7:0] wdata);
    int c;
    logic [NUM_CH-1:0] exp_ack;
    logic [NUM_CH-1:0] exp_wtx;
    @(negedge clk);
    reset               = rst;
    bus.IO_read_strobe  = rd;
    bus.IO_write_strobe = wr;
    bus.IO_port_ID      = port;
    bus.IO_write_data   = wdata;
    exp_ack = '0;
    exp_wtx = '0;
    c = ch_of(port);
    if (rst) begin
      m_rdata = 8'h00;
      m_gpio  = 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
        m_tx[i] = 8'h00; m_scr[i] = 8'h00; m_under[i] = 0; m_drop[i] = 0;
      end
      gin_p1 = 8'h00;
      gin_p2 = 8'h00;
    end else begin
      if (rd) begin
        m_rdata = model_read(port);
        if (c >= 0 && off_of(port) == 0) begin
          if (uart_rx_present[c]) exp_ack[c] = 1'b1;
          else                    m_under[c] = 1;
        end
      end else if (wr) begin
        if (c >= 0) begin
          case (off_of(port))
            0: if (!uart_tx_full[c]) begin m_tx[c] = wdata; exp_wtx[c] = 1'b1; end
               else m_drop[c] = 1;
            2: if (wdata[0]) begin m_under[c] = 0; m_drop[c] = 0; end
            3: m_scr[c] = wdata;
            default: ;
          endcase
        end else if (port == GPIO_OUT_PORT) begin
          m_gpio = wdata;
        end
      end
      gin_p2 = gin_p1;
      gin_p1 = gpio_in;
    end
    @(posedge clk);
    #1;
    check("read_data", bus.IO_read_data, m_rdata);
    check("write_tx", uart_write_tx, exp_wtx);
    check("read_ack", uart_read_ack, exp_ack);
    check("gpio_out", gpio_out, m_gpio);
    for (int i = 0; i < NUM_CH; i++) check("tx_data", uart_tx_data[8*i +: 8], m_tx[i]);
    bus.IO_read_strobe  = 1'b0;
    bus.IO_write_strobe = 1'b0;
  endtask

  task automatic rd_op(input logic [7:0] port);
    do_op(0, 1, 0, port, 8'h00);
  endtask

  task automatic wr_op(input logic [7:0] port, input logic [7:0] data);
    do_op(0, 0, 1, port, data);
  endtask

  task automatic idle();
    do_op(0, 0, 0, 8'hFF, 8'h00);
  endtask

  initial begin
    logic [7:0] port;
    int         sel;
    bus.IO_port_ID      = 8'h00;
    bus.IO_write_data   = 8'h00;
    bus.IO_write_strobe = 1'b0;
    bus.IO_read_strobe  = 1'b0;

    // Reset with a strobe present: it must be ignored
    do_op(1, 0, 1, GPIO_OUT_PORT, 8'hEE);
    do_op(1, 1, 0, 8'h10, 8'h00);
    check("reset_gpio_out", gpio_out, 8'h00);
    check("reset_rdata", bus.IO_read_data, 8'h00);

    // 1: read every mapped port after reset
    uart_rx_present = 2'b01;
    for (int p = 8'h10; p < 8'h18; p++) rd_op(8'(p));
    rd_op(GPIO_OUT_PORT);
    rd_op(GPIO_IN_PORT);
    rd_op(8'h11);
    check("status_live_rx", bus.IO_read_data, 8'h01);
    rd_op(8'h18);
    check("unmapped_above", bus.IO_read_data, 8'h00);
    rd_op(8'h0F);
    check("unmapped_below", bus.IO_read_data, 8'h00);

    // 2: channel 1 receive with ack pulse
    uart_rx_present = 2'b10;
    uart_rx_data    = {8'hA5, 8'h00};
    rd_op(8'h14);
    check("rx_ch1_data", bus.IO_read_data, 8'hA5);
    check("rx_ch1_ack", uart_read_ack, 2'b10);
    idle();
    check("rx_ch1_ack_end", uart_read_ack, 2'b00);
    check("rx_data_holds", bus.IO_read_data, 8'hA5);

    // 3: channel 0 transmit, then dropped write
    uart_rx_present = 2'b00;
    uart_tx_full    = 2'b00;
    wr_op(8'h10, 8'h3C);
    check("tx_ch0_byte", uart_tx_data[7:0], 8'h3C);
    check("tx_ch0_pulse", uart_write_tx, 2'b01);
    uart_tx_full = 2'b01;
    wr_op(8'h10, 8'h77);
    check("tx_full_nopulse", uart_write_tx, 2'b00);
    rd_op(8'h11);
    check("status_dropped", bus.IO_read_data, 8'h0A);

    // 4: underflow, then control clear
    uart_tx_full = 2'b00;
    rd_op(8'h10);
    check("underflow_data", bus.IO_read_data, 8'h00);
    check("underflow_noack", uart_read_ack, 2'b00);
    rd_op(8'h11);
    check("status_underflow", 32'(bus.IO_read_data[2]), 32'd1);
    wr_op(8'h12, 8'h01);
    rd_op(8'h11);
    check("status_cleared", bus.IO_read_data, 8'h00);

    // 5: GPIO out, scratch, GPIO in synchroniser latency
    wr_op(GPIO_OUT_PORT, 8'h5A);
    wr_op(8'h17, 8'hC3);
    check("gpio_out_val", gpio_out, 8'h5A);
    rd_op(GPIO_OUT_PORT);
    check("gpio_readback", bus.IO_read_data, 8'h5A);
    rd_op(8'h17);
    check("scratch_readback", bus.IO_read_data, 8'hC3);
    gpio_in = 8'h81;
    rd_op(GPIO_IN_PORT);
    rd_op(GPIO_IN_PORT);
    rd_op(GPIO_IN_PORT);
    check("gpio_in_sync", bus.IO_read_data, 8'h81);

    // 6: simultaneous strobes, then reset during a TX pulse
    uart_rx_present = 2'b01;
    uart_rx_data    = {8'h00, 8'h42};
    do_op(0, 1, 1, 8'h10, 8'h99);
    check("rw_read_wins", bus.IO_read_data, 8'h42);
    check("rw_no_tx", uart_write_tx, 2'b00);
    uart_rx_present = 2'b00;
    rd_op(8'h14);
    wr_op(8'h10, 8'h66);
    check("pre_reset_pulse", uart_write_tx, 2'b01);
    do_op(1, 0, 0, 8'h00, 8'h00);
    check("reset_kills_pulse", uart_write_tx, 2'b00);
    rd_op(8'h15);
    check("reset_clears_flags", bus.IO_read_data, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      uart_rx_present = NUM_CH'($urandom);
      uart_tx_full    = NUM_CH'($urandom);
      uart_rx_data    = (8*NUM_CH)'($urandom);
      if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 7)       port = BASE_PORT + 8'($urandom_range(0, 4 * NUM_CH - 1));
      else if (sel == 7) port = GPIO_OUT_PORT;
      else if (sel == 8) port = GPIO_IN_PORT;
      else               port = 8'($urandom);
      do_op($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, port, 8'($urandom));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
